// File: rtl/dma_controller.sv
// Bus-mastering DMA: on start it requests the M2 bus, copies NUM_BLOCKS device blocks
// into data memory at base + 4*k, then releases the bus and pulses an end interrupt.
module dma_controller #(
  parameter int WORD_SIZE  = 16,
  parameter int BLOCK_SIZE = 64,
  parameter int NUM_BLOCKS = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  dma_start,
  input  logic [WORD_SIZE-1:0]  dma_set_address,
  input  logic [BLOCK_SIZE-1:0] dev_data,
  output logic [1:0]            dev_block,
  output logic                  BR,
  input  logic                  BG,
  output logic                  dma_writeM2,
  output logic [WORD_SIZE-1:0]  dma_address2,
  output logic [BLOCK_SIZE-1:0] dma_data2,
  input  logic                  M2busy,
  output logic                  dma_end_interrupt,
  output logic                  dma_busy,
  output logic [2:0]            dbg_state
);
  // Handshakes: BR stays high from start until the last block completes; a block is
  // issued only in a cycle after BG was sampled high, and a memory write is complete
  // once M2busy has been seen high and then low again.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WRITE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam logic [1:0] LAST = 2'(NUM_BLOCKS - 1);

  state_t                state;
  logic [WORD_SIZE-1:0]  base;
  logic [WORD_SIZE-1:0]  addr_q;
  logic [BLOCK_SIZE-1:0] data_q;
  logic [1:0]            k;
  logic [1:0]            k_inc;
  logic                  drive;

  assign k_inc        = k + 2'd1;
  assign dma_address2 = drive ? addr_q : {WORD_SIZE{1'bz}};
  assign dma_data2    = drive ? data_q : {BLOCK_SIZE{1'bz}};
  assign dbg_state    = state;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state             <= IDLE;
      base              <= '0;
      addr_q            <= '0;
      data_q            <= '0;
      k                 <= '0;
      drive             <= 1'b0;
      dev_block         <= '0;
      BR                <= 1'b0;
      dma_writeM2       <= 1'b0;
      dma_end_interrupt <= 1'b0;
      dma_busy          <= 1'b0;
    end else begin
      dma_writeM2       <= 1'b0;
      dma_end_interrupt <= 1'b0;
      case (state)
        IDLE: begin
          // dma_busy is still high during the end-pulse cycle, so a start there is ignored.
          if (dma_start && !dma_busy) begin
            base      <= dma_set_address;
            k         <= '0;
            dev_block <= '0;
            BR        <= 1'b1;
            dma_busy  <= 1'b1;
            state     <= REQ;
          end else begin
            dma_busy <= 1'b0;
          end
        end
        REQ: begin
          if (BG) begin
            addr_q      <= base + (WORD_SIZE'(k) << 2);
            data_q      <= dev_data;
            drive       <= 1'b1;
            dma_writeM2 <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: state <= WAIT_HI;
        WAIT_HI: begin
          // Pre-select the next device block so its data is settled when WAIT_LO ends.
          if (M2busy) begin
            if (k != LAST) dev_block <= k_inc;
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!M2busy) begin
            k <= k_inc;
            if (k == LAST) begin
              BR    <= 1'b0;
              drive <= 1'b0;
              state <= RELEASE;
            end else if (BG) begin
              addr_q      <= base + (WORD_SIZE'(k_inc) << 2);
              data_q      <= dev_data;
              dma_writeM2 <= 1'b1;
              state       <= WRITE;
            end else begin
              drive <= 1'b0;
              state <= REQ;
            end
          end
        end
        RELEASE: begin
          if (!BG) begin
            dma_end_interrupt <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
